// File: rtl/sm_adder_pkg.sv
// Shared definitions for the ROM-based sign-magnitude adder: address sizing
// and the constant function that builds each ROM word.
package sm_adder_pkg;

    localparam int DATA_WIDTH = 4;
    localparam int ADDR_W     = 2 * DATA_WIDTH;
    localparam int ROM_DEPTH  = 2 ** ADDR_W;

    // Widest word the function can return (DATA_WIDTH up to 8, plus the sign).
    localparam int MAX_WORD_W = 9;

    function automatic logic [MAX_WORD_W-1:0] sm_add_word(
        input int unsigned a,
        input int unsigned b,
        input int unsigned width
    );
        int unsigned mag_mask;
        int unsigned sa;
        int unsigned sb;
        int unsigned ma;
        int unsigned mb;
        int unsigned mag;
        int unsigned sign;
        int unsigned word;
        mag_mask = (32'd1 << (width - 32'd1)) - 32'd1;
        sa       = (a >> (width - 32'd1)) & 32'd1;
        sb       = (b >> (width - 32'd1)) & 32'd1;
        ma       = a & mag_mask;
        mb       = b & mag_mask;
        if (sa == sb) begin
            mag  = ma + mb;
            sign = sa;
        end else if (ma > mb) begin
            mag  = ma - mb;
            sign = sa;
        end else if (mb > ma) begin
            mag  = mb - ma;
            sign = sb;
        end else begin
            mag  = 32'd0;
            sign = 32'd0;
        end
        // Zero is always reported as +0, including -0 + -0.
        if (mag == 32'd0) begin
            sign = 32'd0;
        end
        word = (sign << width) | mag;
        return word[MAX_WORD_W-1:0];
    endfunction

endpackage

// File: rtl/rom_based_sign_magnitude_adder_sm_add_rom.sv
// Constant sum ROM indexed by {a, b}, with a synchronous read register that
// clears asynchronously on an active-low reset.
module sm_add_rom
    import sm_adder_pkg::*;
#(
    parameter int DATA_WIDTH = sm_adder_pkg::DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [2*DATA_WIDTH-1:0]   addr,
    output logic [DATA_WIDTH:0]       data
);

    localparam int RA_W   = 2 * DATA_WIDTH;
    localparam int RDEPTH = 2 ** RA_W;

    logic [DATA_WIDTH:0] rom [RDEPTH];

    for (genvar i = 0; i < RDEPTH; i++) begin : g_rom
        localparam logic [MAX_WORD_W-1:0] WORD = sm_add_word(
            (i >> DATA_WIDTH), (i % (2 ** DATA_WIDTH)), DATA_WIDTH);
        assign rom[i] = WORD[DATA_WIDTH:0];
    end

    // The read register is the only state; operands are free-running, no
    // handshake: every edge captures the word for the current address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else begin
            data <= rom[addr];
        end
    end

endmodule

// File: rtl/rom_based_sign_magnitude_adder.sv
// Sign-magnitude adder with one cycle of latency: the operand pair addresses
// a precomputed sum ROM whose registered output is the result.
module rom_based_sign_magnitude_adder
    import sm_adder_pkg::*;
#(
    parameter int DATA_WIDTH = sm_adder_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH:0]   sum
);

    logic [2*DATA_WIDTH-1:0] rom_addr;

    assign rom_addr = {a, b};

    sm_add_rom #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rom (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (rom_addr),
        .data  (sum)
    );

endmodule

// File: tb/tb_rom_based_sign_magnitude_adder.sv
// Scoreboard bench for the ROM-based sign-magnitude adder (DATA_WIDTH = 4).
module tb_rom_based_sign_magnitude_adder;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   sum;

    logic         issued;
    logic [W:0]   exp_q[$];
    int           tests;
    int           fails;

    rom_based_sign_magnitude_adder #(
        .DATA_WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .sum   (sum)
    );

    // Clock / reset-time initialisation
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model via signed integer arithmetic.
    function automatic logic [W:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] y);
        int vx;
        int vy;
        int s;
        int unsigned m;
        logic [W:0] r;
        vx = x[W-1] ? -int'(x[W-2:0]) : int'(x[W-2:0]);
        vy = y[W-1] ? -int'(y[W-2:0]) : int'(y[W-2:0]);
        s  = vx + vy;
        m  = (s < 0) ? -s : s;
        r  = {(s < 0), m[W-1:0]};
        return r;
    endfunction

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Driver: operands change on the falling edge and are sampled on the next rising edge.
    task automatic apply(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W:0] exp);
        @(negedge clk);
        a      = x;
        b      = y;
        issued = 1'b1;
        exp_q.push_back(exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            issued = 1'b0;
        end
    endtask

    // Monitor: any rising edge that captured an issued vector yields one result.
    initial begin
        logic take;
        logic [W:0] e;
        forever begin
            @(posedge clk);
            take = issued;
            #1;
            if (take) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL scoreboard_underflow: got %b expected none", sum);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("sum a=%b b=%b", dut.a, dut.b), sum, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests  = 0;
        fails  = 0;
        issued = 1'b0;
        rst_n  = 1'b0;
        a      = 4'b0100;
        b      = 4'b0001;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_hold", sum, 5'b00000);
        rst_n = 1'b1;

        // Same sign
        apply(4'b0100, 4'b0001, 5'b00101);
        apply(4'b1100, 4'b1001, 5'b10101);
        apply(4'b0001, 4'b0100, 5'b00101);
        apply(4'b1001, 4'b1100, 5'b10101);
        // Mixed sign
        apply(4'b0100, 4'b1001, 5'b00011);
        apply(4'b1100, 4'b0001, 5'b10011);
        apply(4'b0001, 4'b1100, 5'b10011);
        apply(4'b1001, 4'b0100, 5'b00011);
        // Extremes
        apply(4'b0111, 4'b0111, 5'b01110);
        apply(4'b1111, 4'b1111, 5'b11110);
        apply(4'b0011, 4'b1111, 5'b10100);
        // Zeros
        apply(4'b0101, 4'b1101, 5'b00000);
        apply(4'b1000, 4'b1000, 5'b00000);
        apply(4'b1000, 4'b0011, 5'b00011);
        apply(4'b0111, 4'b0111, 5'b01110);
        idle(3);

        // Asynchronous clear mid-cycle, away from any rising edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_clear", sum, 5'b00000);
        @(posedge clk);
        #1;
        check("async_reset_hold", sum, 5'b00000);
        @(negedge clk);
        rst_n = 1'b1;

        // Exhaustive, back-to-back
        for (int i = 0; i < 256; i++) begin
            logic [7:0] ab;
            ab = i[7:0];
            apply(ab[7:4], ab[3:0], ref_sum(ab[7:4], ab[3:0]));
        end
        idle(4);

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
